instr_decode_ctrl: RTL and testbench

INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

---
 rtl/instr_decode_ctrl.sv | 159 +++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_ctrl.sv
// Fetch/execute sequencer: decodes one 16-bit instruction every two cycles and
// issues registered jump/roll-over commands to the program counter.
module instr_decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr_in,
    output logic [1:0]  jump_control,
    output logic        eq_flag,
    output logic [11:0] load_data,
    output logic        roll_over,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_JEQ  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_LDC  = 4'h5;
    localparam logic [3:0] OP_DJNZ = 4'h6;
    localparam logic [3:0] OP_RST  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_JEQ  = 2'b10;
    localparam logic [1:0] PC_JMP  = 2'b11;

    state_t      state_reg, state_next;
    logic [1:0]  jc_reg, jc_next;
    logic        eq_reg, eq_next;
    logic [11:0] ld_reg, ld_next;
    logic        ro_reg, ro_next;
    logic        halted_reg, halted_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  c_reg, c_next;
    logic [15:0] ir_reg, ir_next;

    // Outputs for EXEC are decoded straight from the ROM word so they are
    // valid on the edge entering EXEC; ir drives decisions made later.
    logic [15:0] cur_instr;
    logic [3:0]  cur_op;
    logic [11:0] cur_operand;
    logic [7:0]  c_dec;

    assign cur_instr   = (state_reg == FETCH) ? instr_in : ir_reg;
    assign cur_op      = cur_instr[15:12];
    assign cur_operand = cur_instr[11:0];
    assign c_dec       = c_reg - 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FETCH;
            jc_reg     <= PC_HOLD;
            eq_reg     <= 1'b0;
            ld_reg     <= 12'd0;
            ro_reg     <= 1'b0;
            halted_reg <= 1'b0;
            cnt_reg    <= 16'd0;
            a_reg      <= 8'd0;
            c_reg      <= 8'd0;
            ir_reg     <= 16'd0;
        end else begin
            state_reg  <= state_next;
            jc_reg     <= jc_next;
            eq_reg     <= eq_next;
            ld_reg     <= ld_next;
            ro_reg     <= ro_next;
            halted_reg <= halted_next;
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            c_reg      <= c_next;
            ir_reg     <= ir_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        jc_next     = jc_reg;
        eq_next     = eq_reg;
        ld_next     = ld_reg;
        ro_next     = ro_reg;
        halted_next = halted_reg;
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        c_next      = c_reg;
        ir_next     = ir_reg;

        case (state_reg)
            FETCH: begin
                state_next = EXEC;
                ir_next    = instr_in;
                cnt_next   = cnt_reg + 16'd1;
                jc_next    = PC_INC;
                ro_next    = 1'b0;
                case (cur_op)
                    OP_LDA:  a_next  = cur_operand[7:0];
                    OP_CMP:  eq_next = (a_reg == cur_operand[7:0]);
                    OP_JEQ: begin
                        jc_next = PC_JEQ;
                        ld_next = cur_operand;
                    end
                    OP_JMP: begin
                        jc_next = PC_JMP;
                        ld_next = cur_operand;
                    end
                    OP_LDC:  c_next  = cur_operand[7:0];
                    OP_DJNZ: begin
                        c_next = c_dec;
                        if (c_dec != 8'd0) begin
                            jc_next = PC_JMP;
                            ld_next = cur_operand;
                        end
                    end
                    OP_RST: begin
                        jc_next = PC_HOLD;
                        ro_next = 1'b1;
                    end
                    OP_HALT: jc_next = PC_HOLD;
                    default: jc_next = PC_INC;
                endcase
            end
            EXEC: begin
                jc_next = PC_HOLD;
                ro_next = 1'b0;
                if (cur_op == OP_HALT) begin
                    state_next  = HALT;
                    halted_next = 1'b1;
                end else begin
                    state_next = FETCH;
                end
            end
            HALT: begin
                jc_next = PC_HOLD;
                if (start) begin
                    state_next  = FETCH;
                    halted_next = 1'b0;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    assign jump_control = jc_reg;
    assign eq_flag      = eq_reg;
    assign load_data    = ld_reg;
    assign roll_over    = ro_reg;
    assign halted       = halted_reg;
    assign instr_count  = cnt_reg;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Self-checking bench for instr_decode_ctrl: an instruction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_instr_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] instr_in;
    logic [1:0]  jump_control;
    logic        eq_flag;
    logic [11:0] load_data;
    logic        roll_over;
    logic        halted;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_decode_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .instr_in     (instr_in),
        .jump_control (jump_control),
        .eq_flag      (eq_flag),
        .load_data    (load_data),
        .roll_over    (roll_over),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: where the machine is in its instruction, plus architectural values.
    int          m_phase;   // 0 = waiting for a fetch, 1 = executing, 2 = halted
    logic [3:0]  m_op;
    logic [7:0]  m_a, m_c;
    logic        m_eq, m_ro, m_halted;
    logic [1:0]  m_jc;
    logic [11:0] m_ld;
    logic [15:0] m_cnt;

    task automatic model_update(input logic r, input logic s, input logic [15:0] w);
        logic [3:0]  op;
        logic [11:0] opd;
        if (r) begin
            m_phase = 0; m_op = 4'h0; m_a = 8'h00; m_c = 8'h00; m_eq = 1'b0;
            m_ro = 1'b0; m_halted = 1'b0; m_jc = 2'd0; m_ld = 12'h000; m_cnt = 16'h0000;
        end else if (m_phase == 0) begin
            op  = w[15:12];
            opd = w[11:0];
            m_op  = op;
            m_cnt = m_cnt + 16'd1;
            m_ro  = (op == 4'h7);
            if (op == 4'h1) m_a = opd[7:0];
            if (op == 4'h2) m_eq = (m_a == opd[7:0]);
            if (op == 4'h5) m_c = opd[7:0];
            if (op == 4'h6) m_c = m_c - 8'd1;
            if (op == 4'h7 || op == 4'hF) m_jc = 2'd0;
            else if (op == 4'h3) m_jc = 2'd2;
            else if (op == 4'h4) m_jc = 2'd3;
            else if (op == 4'h6 && m_c != 8'd0) m_jc = 2'd3;
            else m_jc = 2'd1;
            if (m_jc[1]) m_ld = opd;
            m_phase = 1;
            $display("exec op=%h operand=%h jc=%0d ld=%h cnt=%0d", op, opd, m_jc, m_ld, m_cnt);
        end else if (m_phase == 1) begin
            m_jc = 2'd0;
            m_ro = 1'b0;
            m_halted = (m_op == 4'hF);
            m_phase  = m_halted ? 2 : 0;
        end else begin
            m_jc = 2'd0;
            if (s) begin
                m_halted = 1'b0;
                m_phase  = 0;
            end
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("jump_control", int'(jump_control), int'(m_jc));
        cmp("eq_flag",      int'(eq_flag),      int'(m_eq));
        cmp("load_data",    int'(load_data),    int'(m_ld));
        cmp("roll_over",    int'(roll_over),    int'(m_ro));
        cmp("halted",       int'(halted),       int'(m_halted));
        cmp("instr_count",  int'(instr_count),  int'(m_cnt));
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] w);
        rst = r; start = s; instr_in = w;
        @(posedge clk);
        #1;
        model_update(r, s, w);
        check_model();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; instr_in = 16'h0000;
        m_phase = 0;
        model_update(1'b1, 1'b0, 16'h0000);

        // Reset values
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'hF000);
        cmp("rst_jc", int'(jump_control), 0);
        cmp("rst_cnt", int'(instr_count), 0);
        cmp("rst_ld", int'(load_data), 0);

        // NOP stream: 01,00 alternating, three retired after six cycles
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            cmp("nop_jc", int'(jump_control), (i % 2 == 0) ? 1 : 0);
        end
        cmp("nop_cnt", int'(instr_count), 3);

        // LDA 2D, CMP 2D, JEQ 004
        step(1'b0, 1'b0, 16'h102D); step(1'b0, 1'b0, 16'h102D);
        step(1'b0, 1'b0, 16'h202D);
        cmp("cmp_eq_hit", int'(eq_flag), 1);
        step(1'b0, 1'b0, 16'h202D);
        step(1'b0, 1'b0, 16'h3004);
        cmp("jeq_jc", int'(jump_control), 2);
        cmp("jeq_ld", int'(load_data), 12'h004);
        cmp("jeq_eq", int'(eq_flag), 1);
        step(1'b0, 1'b0, 16'h3004);

        // LDA 05, CMP 06, JEQ 100
        step(1'b0, 1'b0, 16'h1005); step(1'b0, 1'b0, 16'h1005);
        step(1'b0, 1'b0, 16'h2006); step(1'b0, 1'b0, 16'h2006);
        cmp("cmp_eq_miss", int'(eq_flag), 0);
        step(1'b0, 1'b0, 16'h3100);
        cmp("jeq2_jc", int'(jump_control), 2);
        cmp("jeq2_ld", int'(load_data), 12'h100);
        step(1'b0, 1'b0, 16'h3100);

        // LDC 03, DJNZ 010 x3: jump, jump, fall through
        step(1'b0, 1'b0, 16'h5003); step(1'b0, 1'b0, 16'h5003);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h6010);
            cmp("djnz_jc", int'(jump_control), (i < 2) ? 3 : 1);
            cmp("djnz_ld", int'(load_data), 12'h010);
            step(1'b0, 1'b0, 16'h6010);
        end
        cmp("djnz_c", int'(dut.c_reg), 0);

        // RST pulse then HALT until start
        step(1'b0, 1'b0, 16'h7000);
        cmp("rst_op_ro", int'(roll_over), 1);
        cmp("rst_op_jc", int'(jump_control), 0);
        step(1'b0, 1'b0, 16'h7000);
        cmp("rst_op_ro_clr", int'(roll_over), 0);
        step(1'b0, 1'b0, 16'hF000);
        step(1'b0, 1'b0, 16'hF000);
        cmp("halt_hi", int'(halted), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h4055);
        cmp("halt_hold", int'(halted), 1);
        cmp("halt_jc", int'(jump_control), 0);
        step(1'b0, 1'b1, 16'h4055);
        cmp("halt_released", int'(halted), 0);

        // rst during JMP EXEC clears everything
        step(1'b0, 1'b0, 16'h4ABC);
        cmp("jmp_jc", int'(jump_control), 3);
        cmp("jmp_ld", int'(load_data), 12'hABC);
        step(1'b1, 1'b1, 16'h4ABC);
        cmp("jmp_rst_ld", int'(load_data), 0);
        cmp("jmp_rst_cnt", int'(instr_count), 0);
        cmp("jmp_rst_eq", int'(eq_flag), 0);

        // Randomized stream: low-operand bias makes CMP hits and DJNZ zero likelier
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] w;
            logic r, s;
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 0) w[7:0] = 8'($urandom_range(0, 3));
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 3) == 0);
            step(r, s, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
